// File: rtl/conv_layer_pkg.sv
// -----------------------------------------------------------------------------
// conv_layer_pkg
// Shared encodings for the convolution input window block:
//   state_e     : FSM state codes (also driven out on current_state)
//   cmd_e       : upstream command codes sampled in IDLE
//   ack_e       : one-cycle completion pulse codes
//   FLOAT32_ONE : IEEE-754 single-precision 1.0, presented during the bias cycle
// No ports (package only).
// -----------------------------------------------------------------------------
package conv_layer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_BIAS    = 3'd3,
    ST_LOAD    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_PRELOAD = 2'd1,
    CMD_SHIFT   = 2'd2,
    CMD_LOAD    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ACK_IDLE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_e;

  localparam logic [31:0] FLOAT32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/conv_layer_row_store.sv
// -----------------------------------------------------------------------------
// conv_layer_row_store
// Holds SLOTS rows of WORDS pixel words each. One word-wide write port and a
// full-row parallel read of the selected slot. Contents are not reset.
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_slot  in   row slot to write
//   i_wr_col   in   word position inside the row
//   i_wr_data  in   word to store
//   i_rd_slot  in   row slot presented on o_rd_row
//   o_rd_row   out  all WORDS words of the selected slot, word j at [(j+1)*WIDTH-1:j*WIDTH]
// -----------------------------------------------------------------------------
module conv_layer_row_store
  import conv_layer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLOTS = 3,
  parameter int WORDS = 6,
  localparam int SLOT_W = $clog2(SLOTS),
  localparam int COL_W  = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [SLOT_W-1:0]        i_wr_slot,
  input  logic [COL_W-1:0]         i_wr_col,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [SLOT_W-1:0]        i_rd_slot,
  output logic [WORDS*WIDTH-1:0]   o_rd_row
);

  logic [WIDTH-1:0] r_mem [SLOTS][WORDS];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_slot][i_wr_col] <= i_wr_data;
    end
  end

  // The whole row is needed at once so any column offset can be muxed out.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_rd
      assign o_rd_row[gi*WIDTH +: WIDTH] = r_mem[i_rd_slot][gi];
    end
  endgenerate

endmodule

// File: rtl/conv_layer_input_window.sv
// -----------------------------------------------------------------------------
// conv_layer_input_window
// Keeps K rows of INPUT_SIZE = A+K-1 pixel words in a circular store and, on
// command, walks the K x K kernel positions presenting A adjacent words per
// step on A parallel output ports.
// Optional feature macro: CONV_INPUT_BIAS_EN -- adds one BIAS cycle after the
// window walk that presents FLOAT32_ONE on every port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd             command (sampled in IDLE only)
//   data_in         pixel word from upstream, qualified by data_in_valid
//   data_in_ready   high in PRELOAD and LOAD
//   ack             one-cycle completion pulse
//   current_state   FSM state code
//   data_out_port   A window words, port i at [(i+1)*WIDTH-1:i*WIDTH]
//   data_out_valid  data_out_port carries a window or bias word
//   row_idx/col_idx kernel position of the presented window
// -----------------------------------------------------------------------------
module conv_layer_input_window
  import conv_layer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int ARRAY_SIZE  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  cmd,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [1:0]                  ack,
  output logic [2:0]                  current_state,
  output logic [ARRAY_SIZE*WIDTH-1:0] data_out_port,
  output logic                        data_out_valid,
  output logic [2:0]                  row_idx,
  output logic [2:0]                  col_idx
);

  localparam int K          = KERNEL_SIZE;
  localparam int A          = ARRAY_SIZE;
  localparam int INPUT_SIZE = A + K - 1;
  localparam int SLOT_W     = $clog2(K);
  localparam int COL_W      = $clog2(INPUT_SIZE);
  localparam int RV_W       = $clog2(K + 1);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(K - 1);
  localparam logic [SLOT_W:0]   K_EXT     = (SLOT_W + 1)'(K);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(INPUT_SIZE - 1);
  localparam logic [RV_W-1:0]   RV_FULL   = RV_W'(K);

  state_e                    r_state;
  state_e                    w_state_next;
  logic [RV_W-1:0]           r_rows_valid;
  logic [SLOT_W-1:0]         r_top_ptr;
  logic [SLOT_W-1:0]         r_wr_row;
  logic [COL_W-1:0]          r_wr_col;
  logic [SLOT_W-1:0]         r_step_row;
  logic [SLOT_W-1:0]         r_step_col;
  ack_e                      r_done;
  ack_e                      w_done_code;
  ack_e                      r_ack;
  logic [A*WIDTH-1:0]        r_data_out;
  logic                      r_valid;
  logic [2:0]                r_row_idx;
  logic [2:0]                r_col_idx;

  logic                      w_accept;
  logic                      w_row_end;
  logic                      w_rows_full;
  logic                      w_preload_last;
  logic                      w_load_last;
  logic                      w_shift_last;
  logic [SLOT_W-1:0]         w_wr_slot;
  logic [SLOT_W:0]           w_rd_sum;
  logic [SLOT_W-1:0]         w_rd_slot;
  logic [INPUT_SIZE*WIDTH-1:0] w_rd_row;
  logic [A*WIDTH-1:0]        w_window;

  assign data_in_ready  = (r_state == ST_PRELOAD) || (r_state == ST_LOAD);
  assign current_state  = r_state;
  assign ack            = r_ack;
  assign data_out_port  = r_data_out;
  assign data_out_valid = r_valid;
  assign row_idx        = r_row_idx;
  assign col_idx        = r_col_idx;

  assign w_accept       = data_in_ready && data_in_valid;
  assign w_row_end      = (r_wr_col == LAST_COL);
  assign w_rows_full    = (r_rows_valid == RV_FULL);
  assign w_preload_last = (r_state == ST_PRELOAD) && w_accept && w_row_end && (r_wr_row == LAST_SLOT);
  assign w_load_last    = (r_state == ST_LOAD) && w_accept && w_row_end;
  assign w_shift_last   = (r_state == ST_SHIFT) && (r_step_row == LAST_SLOT) && (r_step_col == LAST_SLOT);

  // PRELOAD fills slots in order; LOAD always replaces the oldest row.
  assign w_wr_slot = (r_state == ST_PRELOAD) ? r_wr_row : r_top_ptr;

  // Kernel row r lives in slot (top_ptr + r) mod K.
  assign w_rd_sum  = {1'b0, r_top_ptr} + {1'b0, r_step_row};
  assign w_rd_slot = (w_rd_sum >= K_EXT) ? SLOT_W'(w_rd_sum - K_EXT) : SLOT_W'(w_rd_sum);

  conv_layer_row_store #(
    .WIDTH (WIDTH),
    .SLOTS (K),
    .WORDS (INPUT_SIZE)
  ) u_row_store (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_slot (w_wr_slot),
    .i_wr_col  (r_wr_col),
    .i_wr_data (data_in),
    .i_rd_slot (w_rd_slot),
    .o_rd_row  (w_rd_row)
  );

  // Port i takes row word i + column offset.
  generate
    for (genvar gi = 0; gi < A; gi++) begin : g_win
      logic [COL_W-1:0] w_sel;
      assign w_sel = COL_W'(gi) + COL_W'(r_step_col);
      assign w_window[gi*WIDTH +: WIDTH] = w_rd_row[w_sel*WIDTH +: WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        case (cmd)
          CMD_PRELOAD: w_state_next = ST_PRELOAD;
          CMD_SHIFT:   if (w_rows_full) w_state_next = ST_SHIFT;
          CMD_LOAD:    if (w_rows_full) w_state_next = ST_LOAD;
          default:     w_state_next = ST_IDLE;
        endcase
      end
      ST_PRELOAD: if (w_preload_last) w_state_next = ST_IDLE;
      ST_LOAD:    if (w_load_last) w_state_next = ST_IDLE;
      ST_SHIFT: begin
        if (w_shift_last) begin
`ifdef CONV_INPUT_BIAS_EN
          w_state_next = ST_BIAS;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Completion is flagged on the final operating cycle and surfaces on ack one
  // cycle later, i.e. just after the last registered output word.
  always_comb begin
    w_done_code = ACK_IDLE;
    if (w_preload_last) begin
      w_done_code = ACK_PRELOAD_FIN;
    end else if (w_load_last) begin
      w_done_code = ACK_LOAD_FIN;
`ifdef CONV_INPUT_BIAS_EN
    end else if (r_state == ST_BIAS) begin
      w_done_code = ACK_SHIFT_FIN;
`else
    end else if (w_shift_last) begin
      w_done_code = ACK_SHIFT_FIN;
`endif
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows_valid <= '0;
      r_top_ptr    <= '0;
      r_wr_row     <= '0;
      r_wr_col     <= '0;
      r_step_row   <= '0;
      r_step_col   <= '0;
      r_done       <= ACK_IDLE;
      r_ack        <= ACK_IDLE;
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_row_idx    <= '0;
      r_col_idx    <= '0;
    end else begin
      r_done     <= w_done_code;
      r_ack      <= r_done;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_row_idx  <= '0;
      r_col_idx  <= '0;
      case (r_state)
        ST_IDLE: begin
          r_wr_col   <= '0;
          r_step_row <= '0;
          r_step_col <= '0;
          if (cmd == CMD_PRELOAD) begin
            r_rows_valid <= '0;
            r_top_ptr    <= '0;
            r_wr_row     <= '0;
          end
        end
        ST_PRELOAD: begin
          if (w_accept) begin
            if (w_row_end) begin
              r_wr_col     <= '0;
              r_wr_row     <= r_wr_row + SLOT_W'(1);
              r_rows_valid <= r_rows_valid + RV_W'(1);
            end else begin
              r_wr_col <= r_wr_col + COL_W'(1);
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (w_row_end) begin
              r_wr_col  <= '0;
              r_top_ptr <= (r_top_ptr == LAST_SLOT) ? '0 : r_top_ptr + SLOT_W'(1);
            end else begin
              r_wr_col <= r_wr_col + COL_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          r_data_out <= w_window;
          r_valid    <= 1'b1;
          r_row_idx  <= 3'(r_step_row);
          r_col_idx  <= 3'(r_step_col);
          if (r_step_col == LAST_SLOT) begin
            r_step_col <= '0;
            r_step_row <= r_step_row + SLOT_W'(1);
          end else begin
            r_step_col <= r_step_col + SLOT_W'(1);
          end
        end
`ifdef CONV_INPUT_BIAS_EN
        ST_BIAS: begin
          r_data_out <= {A{WIDTH'(FLOAT32_ONE)}};
          r_valid    <= 1'b1;
          r_row_idx  <= 3'(K - 1);
          r_col_idx  <= 3'(K - 1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_input_window.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_input_window
// Directed sequence with randomized data/gaps against a simple array model of
// the K x INPUT_SIZE window store (K=3, A=4, INPUT_SIZE=6).
// -----------------------------------------------------------------------------
module tb_conv_layer_input_window;

  localparam int W  = 32;
  localparam int K  = 3;
  localparam int A  = 4;
  localparam int IS = A + K - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       cmd;
  logic [W-1:0]     data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [1:0]       ack;
  logic [2:0]       current_state;
  logic [A*W-1:0]   data_out_port;
  logic             data_out_valid;
  logic [2:0]       row_idx;
  logic [2:0]       col_idx;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_mem [K][IS];
  int          m_top;

  always #5 clk = ~clk;

  conv_layer_input_window #(
    .WIDTH       (W),
    .KERNEL_SIZE (K),
    .ARRAY_SIZE  (A)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .ack            (ack),
    .current_state  (current_state),
    .data_out_port  (data_out_port),
    .data_out_valid (data_out_valid),
    .row_idx        (row_idx),
    .col_idx        (col_idx)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A*W-1:0] exp_window(input int r, input int s);
    logic [A*W-1:0] v;
    int slot;
    slot = (m_top + r) % K;
    for (int i = 0; i < A; i++) v[i*W +: W] = m_mem[slot][i+s];
    return v;
  endfunction

  task automatic do_preload(input bit gaps, input bit rnd);
    int n;
    int cyc;
    bit v;
    logic [31:0] w;
    cmd = 2'd1; tick; cmd = 2'd0;
    check("preload_state", current_state, 1);
    check("preload_ready", data_in_ready, 1);
    n = 0; cyc = 0;
    while (n < K*IS && cyc < 500) begin
      v = gaps ? (cyc % 2 == 0) : 1'b1;
      w = rnd ? $urandom : 32'(16*(n/IS) + n%IS);
      cmd = 2'($urandom_range(0, 3));
      data_in = v ? w : $urandom;
      data_in_valid = v;
      if (v) begin
        m_mem[n/IS][n%IS] = w;
        n++;
      end
      tick; cyc++;
    end
    data_in_valid = 1'b0; cmd = 2'd0;
    check("preload_words", n, K*IS);
    check("preload_ack_early", ack, 0);
    check("preload_idle", current_state, 0);
    tick;
    check("preload_ack", ack, 1);
    tick;
    check("preload_ack_pulse", ack, 0);
    m_top = 0;
    $display("preload gaps=%0d rnd=%0d cycles=%0d", gaps, rnd, cyc);
  endtask

  task automatic do_load(input bit rnd);
    int n;
    int cyc;
    bit v;
    logic [31:0] w;
    cmd = 2'd3; tick; cmd = 2'd0;
    check("load_state", current_state, 4);
    check("load_ready", data_in_ready, 1);
    n = 0; cyc = 0;
    while (n < IS && cyc < 500) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w = rnd ? $urandom : 32'(48 + n);
      cmd = 2'($urandom_range(0, 3));
      data_in = v ? w : $urandom;
      data_in_valid = v;
      if (v) begin
        m_mem[m_top][n] = w;
        n++;
      end
      tick; cyc++;
    end
    data_in_valid = 1'b0; cmd = 2'd0;
    check("load_words", n, IS);
    check("load_ack_early", ack, 0);
    check("load_idle", current_state, 0);
    tick;
    check("load_ack", ack, 3);
    tick;
    check("load_ack_pulse", ack, 0);
    m_top = (m_top + 1) % K;
    $display("load rnd=%0d cycles=%0d new_top=%0d", rnd, cyc, m_top);
  endtask

  // mode 1: constant check of step (1,2) after directed preload
  // mode 2: constant check of first window after directed load
  task automatic do_shift(input int mode);
    logic [A*W-1:0] c;
    cmd = 2'd2; tick; cmd = 2'd0;
    check("shift_state", current_state, 2);
    check("shift_first_valid", data_out_valid, 0);
    for (int n = 0; n < K*K; n++) begin
      cmd = 2'($urandom_range(0, 3));
      data_in = $urandom;
      data_in_valid = 1'($urandom_range(0, 1));
      tick;
      check("shift_window", data_out_port, exp_window(n / K, n % K));
      check("shift_valid", data_out_valid, 1);
      check("shift_row_idx", row_idx, n / K);
      check("shift_col_idx", col_idx, n % K);
      check("shift_no_ack", ack, 0);
      if (mode == 1 && n == 5) begin
        c = {32'd21, 32'd20, 32'd19, 32'd18};
        check("shift_step_1_2", data_out_port, c);
      end
      if (mode == 2 && n == 0) begin
        c = {32'd19, 32'd18, 32'd17, 32'd16};
        check("shift_after_load_first", data_out_port, c);
      end
    end
    cmd = 2'd0; data_in_valid = 1'b0;
`ifdef CONV_INPUT_BIAS_EN
    tick;
    c = {A{32'h3F80_0000}};
    check("bias_word", data_out_port, c);
    check("bias_valid", data_out_valid, 1);
    check("bias_row_idx", row_idx, K - 1);
    check("bias_col_idx", col_idx, K - 1);
    check("bias_no_ack", ack, 0);
`endif
    tick;
    check("shift_ack", ack, 2);
    check("shift_end_valid", data_out_valid, 0);
    check("shift_end_data", data_out_port, 0);
    check("shift_end_state", current_state, 0);
    tick;
    check("shift_ack_pulse", ack, 0);
    $display("shift mode=%0d top=%0d windows=%0d", mode, m_top, K*K);
  endtask

  initial begin
    rst = 1'b1; cmd = 2'd0; data_in = '0; data_in_valid = 1'b0; m_top = 0;
    tick; tick;
    check("rst_state", current_state, 0);
    check("rst_ack", ack, 0);
    check("rst_data", data_out_port, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_ready", data_in_ready, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_col_idx", col_idx, 0);
    rst = 1'b0;
    tick;

    // shift and load before any preload are dropped
    cmd = 2'd2; tick; cmd = 2'd0;
    check("early_shift_state", current_state, 0);
    check("early_shift_valid", data_out_valid, 0);
    cmd = 2'd3; tick; cmd = 2'd0;
    check("early_load_state", current_state, 0);
    tick; tick;
    check("early_ack", ack, 0);
    $display("early commands dropped");

    do_preload(1'b0, 1'b0);
    do_shift(1);
    do_load(1'b0);
    do_shift(2);

    // reset at shift step 4
    cmd = 2'd2; tick; cmd = 2'd0;
    repeat (4) tick;
    check("mid_rst_pre_state", current_state, 2);
    rst = 1'b1; tick; rst = 1'b0;
    check("mid_rst_state", current_state, 0);
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_data", data_out_port, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_row_idx", row_idx, 0);
    check("mid_rst_col_idx", col_idx, 0);
    repeat (3) begin
      tick;
      check("mid_rst_no_ack", ack, 0);
    end
    cmd = 2'd2; tick; cmd = 2'd0;
    check("post_rst_shift_state", current_state, 0);
    tick;
    check("post_rst_shift_valid", data_out_valid, 0);
    check("post_rst_shift_ack", ack, 0);
    $display("reset during shift step 4");

    do_preload(1'b1, 1'b1);
    do_shift(0);
    do_shift(0);
    repeat (4) begin
      do_load(1'b1);
      do_shift(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
